// File: rtl/gpio_display.sv
// GPIO word to eight seven-segment displays, hex or decimal (double-dabble) mode.
// Optional macro GPIO_DISP_LEADING_ZERO_BLANK_EN blanks leading zeros in decimal mode.
module gpio_display #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] value,
   input  logic        dec_mode,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [6:0]  hex6,
   output logic [6:0]  hex7,
   output logic        busy,
   output logic        overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_ZERO  = SEG_ACTIVE_LOW ? 7'b1000000 : ~7'b1000000;
   localparam logic [6:0] SEG_DASH  = SEG_ACTIVE_LOW ? 7'b0111111 : ~7'b0111111;
   localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'b1111111 : ~7'b1111111;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'h0:    p = 7'b1000000;
         4'h1:    p = 7'b1111001;
         4'h2:    p = 7'b0100100;
         4'h3:    p = 7'b0110000;
         4'h4:    p = 7'b0011001;
         4'h5:    p = 7'b0010010;
         4'h6:    p = 7'b0000010;
         4'h7:    p = 7'b1111000;
         4'h8:    p = 7'b0000000;
         4'h9:    p = 7'b0010000;
         4'hA:    p = 7'b0001000;
         4'hB:    p = 7'b0000011;
         4'hC:    p = 7'b1000110;
         4'hD:    p = 7'b0100001;
         4'hE:    p = 7'b0000110;
         default: p = 7'b0001110;
      endcase
      return SEG_ACTIVE_LOW ? p : ~p;
   endfunction

   state_t          state_reg, state_next;
   logic [31:0]     src_reg, src_next;
   logic            src_mode_reg, src_mode_next;
   logic [31:0]     shown_value_reg, shown_value_next;
   logic            shown_mode_reg, shown_mode_next;
   logic [39:0]     bcd_reg, bcd_next;
   logic [5:0]      cnt_reg, cnt_next;
   logic [7:0][6:0] hex_reg, hex_next;
   logic            busy_reg, busy_next;
   logic            overflow_reg, overflow_next;

   logic [35:0]     bcd_adj;
   logic [7:0][6:0] seg_hex;
   logic [7:0][6:0] seg_dec;
   logic            dec_overflow;

   assign dec_overflow = |bcd_reg[39:32];

   // Digit 9 never reaches 5 for a 32-bit input, so only digits 0..8 need the +3 correction.
   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                     bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      end
   endgenerate

`ifdef GPIO_DISP_LEADING_ZERO_BLANK_EN
   // lead_zero[k]: decimal digits 7..k are all zero
   logic [8:1] lead_zero;
   assign lead_zero[8] = 1'b1;
`endif

   generate
      for (gi = 0; gi < 8; gi++) begin : g_digit
         assign seg_hex[gi] = glyph(src_reg[4*gi +: 4]);
`ifdef GPIO_DISP_LEADING_ZERO_BLANK_EN
         if (gi == 0) begin : g_lsd
            assign seg_dec[gi] = glyph(bcd_reg[4*gi +: 4]);
         end else begin : g_msd
            assign lead_zero[gi] = lead_zero[gi+1] && (bcd_reg[4*gi +: 4] == 4'd0);
            assign seg_dec[gi]   = lead_zero[gi] ? SEG_BLANK : glyph(bcd_reg[4*gi +: 4]);
         end
`else
         assign seg_dec[gi] = glyph(bcd_reg[4*gi +: 4]);
`endif
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      src_next         = src_reg;
      src_mode_next    = src_mode_reg;
      shown_value_next = shown_value_reg;
      shown_mode_next  = shown_mode_reg;
      bcd_next         = bcd_reg;
      cnt_next         = cnt_reg;
      hex_next         = hex_reg;
      overflow_next    = overflow_reg;

      case (state_reg)
         IDLE: begin
            if ({value, dec_mode} != {shown_value_reg, shown_mode_reg}) begin
               src_next      = value;
               src_mode_next = dec_mode;
               bcd_next      = '0;
               cnt_next      = '0;
               state_next    = dec_mode ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            // src_reg is kept intact for shown_value; its bits are fed MSB-first by count.
            bcd_next = {bcd_reg[38:36], bcd_adj, src_reg[5'd31 - cnt_reg[4:0]]};
            cnt_next = cnt_reg + 6'd1;
            if (cnt_reg == 6'd31) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (!src_mode_reg) begin
               hex_next      = seg_hex;
               overflow_next = 1'b0;
            end else if (dec_overflow) begin
               hex_next      = {8{SEG_DASH}};
               overflow_next = 1'b1;
            end else begin
               hex_next      = seg_dec;
               overflow_next = 1'b0;
            end
            shown_value_next = src_reg;
            shown_mode_next  = src_mode_reg;
            state_next       = IDLE;
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         src_reg         <= '0;
         src_mode_reg    <= 1'b0;
         shown_value_reg <= '0;
         shown_mode_reg  <= 1'b0;
         bcd_reg         <= '0;
         cnt_reg         <= '0;
         hex_reg         <= {8{SEG_ZERO}};
         busy_reg        <= 1'b0;
         overflow_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         src_reg         <= src_next;
         src_mode_reg    <= src_mode_next;
         shown_value_reg <= shown_value_next;
         shown_mode_reg  <= shown_mode_next;
         bcd_reg         <= bcd_next;
         cnt_reg         <= cnt_next;
         hex_reg         <= hex_next;
         busy_reg        <= busy_next;
         overflow_reg    <= overflow_next;
      end
   end

   assign hex0     = hex_reg[0];
   assign hex1     = hex_reg[1];
   assign hex2     = hex_reg[2];
   assign hex3     = hex_reg[3];
   assign hex4     = hex_reg[4];
   assign hex5     = hex_reg[5];
   assign hex6     = hex_reg[6];
   assign hex7     = hex_reg[7];
   assign busy     = busy_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_gpio_display.sv
// Directed bench for gpio_display: reset, hex, decimal, overflow, mid-conversion changes.
module tb_gpio_display;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] value;
   logic        dec_mode;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic        busy;
   logic        overflow;

   int n_checks = 0;
   int n_pass   = 0;

   gpio_display #(.SEG_ACTIVE_LOW(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .value    (value),
      .dec_mode (dec_mode),
      .hex0     (hex0),
      .hex1     (hex1),
      .hex2     (hex2),
      .hex3     (hex3),
      .hex4     (hex4),
      .hex5     (hex5),
      .hex6     (hex6),
      .hex7     (hex7),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [55:0] disp();
      return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
   endfunction

   function automatic logic [6:0] char_seg(input byte c);
      case (c)
         "0":     return 7'h40;
         "1":     return 7'h79;
         "2":     return 7'h24;
         "3":     return 7'h30;
         "4":     return 7'h19;
         "5":     return 7'h12;
         "6":     return 7'h02;
         "7":     return 7'h78;
         "8":     return 7'h00;
         "9":     return 7'h10;
         "A":     return 7'h08;
         "b":     return 7'h03;
         "C":     return 7'h46;
         "d":     return 7'h21;
         "E":     return 7'h06;
         "F":     return 7'h0E;
         "-":     return 7'h3F;
         default: return 7'h7F;
      endcase
   endfunction

   // s[0] is HEX7 (leftmost), s[7] is HEX0
   function automatic logic [55:0] show(input string s);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[55 - 7*i -: 7] = char_seg(s[i]);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic run_req(input string tag, input logic [31:0] v, input logic m,
                          input int exp_cycles, input string exp_s, input logic exp_ovf);
      logic [55:0] prev;
      int          n;
      bit          early;
      @(negedge clk);
      prev     = disp();
      value    = v;
      dec_mode = m;
      n        = 0;
      early    = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         n++;
         if (disp() !== prev) early = 1;
         @(negedge clk);
      end
      check({tag, ".busy_cycles"}, 64'(n), 64'(exp_cycles));
      check({tag, ".early_update"}, 64'(early), 64'd0);
      check({tag, ".display"}, 64'(disp()), 64'(show(exp_s)));
      check({tag, ".overflow"}, 64'(overflow), 64'(exp_ovf));
      @(negedge clk);
      check({tag, ".stays_idle"}, 64'(busy), 64'd0);
      $display("txn %s value=%h dec=%0d busy_cycles=%0d hex=%h ovf=%0d",
               tag, v, m, n, disp(), overflow);
   endtask

   initial begin
      int  n;
      bit  seen;
      rst      = 1'b0;
      value    = 32'd0;
      dec_mode = 1'b0;

      repeat (3) @(negedge clk);
      check("reset.display", 64'(disp()), 64'(show("00000000")));
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.overflow", 64'(overflow), 64'd0);
      rst = 1'b1;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy) seen = 1;
      end
      check("reset.no_start", 64'(seen), 64'd0);
      check("reset.display_after", 64'(disp()), 64'(show("00000000")));
      $display("txn reset hex=%h busy=%0d ovf=%0d", disp(), busy, overflow);

      run_req("hex_12ABCD09", 32'h12AB_CD09, 1'b0, 1, "12AbCd09", 1'b0);
      run_req("dec_12345678", 32'd12_345_678, 1'b1, 33, "12345678", 1'b0);
`ifdef GPIO_DISP_LEADING_ZERO_BLANK_EN
      run_req("dec_42", 32'd42, 1'b1, 33, "      42", 1'b0);
`else
      run_req("dec_42", 32'd42, 1'b1, 33, "00000042", 1'b0);
`endif
      run_req("dec_99999999", 32'd99_999_999, 1'b1, 33, "99999999", 1'b0);
      run_req("dec_100000000", 32'd100_000_000, 1'b1, 33, "--------", 1'b1);
      run_req("dec_FFFFFFFF", 32'hFFFF_FFFF, 1'b1, 33, "--------", 1'b1);
      run_req("mode_only_hex", 32'hFFFF_FFFF, 1'b0, 1, "FFFFFFFF", 1'b0);
      run_req("hex_zero", 32'h0000_0000, 1'b0, 1, "00000000", 1'b0);

      // value changes from 5 to 77 while the conversion of 5 is in SHIFT
      @(negedge clk);
      value    = 32'd5;
      dec_mode = 1'b1;
      repeat (11) @(negedge clk);
      check("mid_change.in_shift", 64'(busy), 64'd1);
      value = 32'd77;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("mid_change.first_len", 64'(n), 64'd23);
`ifdef GPIO_DISP_LEADING_ZERO_BLANK_EN
      check("mid_change.first_display", 64'(disp()), 64'(show("       5")));
`else
      check("mid_change.first_display", 64'(disp()), 64'(show("00000005")));
`endif
      n = 0;
      seen = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (busy) seen = 1;
         if (!busy && seen) break;
      end
      check("mid_change.reasserted", 64'(seen), 64'd1);
      check("mid_change.edges_to_77", 64'(n), 64'd34);
`ifdef GPIO_DISP_LEADING_ZERO_BLANK_EN
      check("mid_change.final_display", 64'(disp()), 64'(show("      77")));
`else
      check("mid_change.final_display", 64'(disp()), 64'(show("00000077")));
`endif
      $display("txn mid_change final hex=%h edges=%0d", disp(), n);

      // reset asserted during SHIFT cycle 20
      @(negedge clk);
      value    = 32'd1234;
      dec_mode = 1'b1;
      repeat (21) @(negedge clk);
      check("mid_reset.in_shift", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      check("mid_reset.busy", 64'(busy), 64'd0);
      check("mid_reset.display", 64'(disp()), 64'(show("00000000")));
      check("mid_reset.overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      value    = 32'd0;
      dec_mode = 1'b0;
      @(negedge clk);
      rst  = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy) seen = 1;
      end
      check("mid_reset.no_start", 64'(seen), 64'd0);
      check("mid_reset.display_after", 64'(disp()), 64'(show("00000000")));
      $display("txn mid_reset hex=%h busy=%0d ovf=%0d", disp(), busy, overflow);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
